mux5_arbiter: RTL and testbench

MUX5_ARBITER -- requirements
Module: mux5_arbiter

---
 rtl/mux5_arbiter_pkg.sv | 28 ++
 rtl/MUX5_1.sv | 29 ++
 rtl/mux5_arbiter.sv | 108 ++++++++++
 tb/tb_mux5_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux5_arbiter_pkg.sv
// Shared definitions for the 5-way round-robin arbiter/multiplexer.
//   N_REQ   : number of requesters (fixed at 5)
//   DATA_W  : default data path width
//   SEL_W   : width of a requester index
//   state_t : output-register FSM encoding (IDLE = empty, BUSY = word held)
//   rr_idx  : modulo-5 index helper used by the round-robin search
package mux5_arbiter_pkg;

  localparam int N_REQ  = 5;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // (base + off) mod N_REQ; base is always a legal index and off < N_REQ,
  // so a single conditional subtract is enough.
  function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base,
                                              input int unsigned       off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/MUX5_1.sv
// 5:1 data multiplexer.
//   i_d0..i_d4 : candidate words
//   i_sel      : index of the word to pass (0..4; other codes give 0)
//   o_y        : selected word (combinational)
module MUX5_1 #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  input  logic [W-1:0] i_d2,
  input  logic [W-1:0] i_d3,
  input  logic [W-1:0] i_d4,
  input  logic [2:0]   i_sel,
  output logic [W-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_sel)
      3'd0:    o_y = i_d0;
      3'd1:    o_y = i_d1;
      3'd2:    o_y = i_d2;
      3'd3:    o_y = i_d3;
      3'd4:    o_y = i_d4;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/mux5_arbiter.sv
// Round-robin arbiter that captures one of five requesters' data words into
// a single-entry output register with valid/ready handshake.
//   clk, rst_n   : clock, synchronous active-low reset
//   req[4:0]     : per-requester valid
//   d0..d4       : requester data
//   gnt[4:0]     : combinational one-hot acknowledge (data captured this edge)
//   sel          : registered index of the requester whose word is held
//   out_data     : registered selected word
//   out_valid    : out_data holds an unconsumed word
//   out_ready    : downstream accepts out_data this cycle
//   xfer_cnt     : wrapping count of completed grants
// Only N_REQ = 5 is supported.
module mux5_arbiter #(
  parameter int DATA_W = 16,
  parameter int N_REQ  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [DATA_W-1:0] d4,
  output logic [N_REQ-1:0]  gnt,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        xfer_cnt
);
  import mux5_arbiter_pkg::*;

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [DATA_W-1:0]  r_data;
  logic [7:0]         r_cnt;

  logic               w_cap;
  logic               w_any;
  logic               w_take;
  logic               w_found;
  logic [SEL_W-1:0]   w_win;
  logic [DATA_W-1:0]  w_mux;

  // The output register can accept a new word when empty, or when the held
  // word is being consumed in this same cycle (no bubble).
  assign w_cap  = (r_state == IDLE) || out_ready;
  assign w_any  = |req;
  // Reset gates the grant so gnt is 0 whenever rst_n is low.
  assign w_take = rst_n && w_cap && w_any;

  // Round-robin search: first set request at or above r_ptr, wrapping 4->0.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[rr_idx(r_ptr, k)]) begin
        w_win   = rr_idx(r_ptr, k);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_take) gnt[w_win] = 1'b1;
  end

  MUX5_1 #(
    .W (DATA_W)
  ) u_mux (
    .i_d0  (d0),
    .i_d1  (d1),
    .i_d2  (d2),
    .i_d3  (d3),
    .i_d4  (d4),
    .i_sel (w_win),
    .o_y   (w_mux)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (w_cap) begin
      if (w_any) begin
        r_data  <= w_mux;
        r_sel   <= w_win;
        r_ptr   <= rr_idx(w_win, 1);
        r_cnt   <= r_cnt + 8'd1;
        r_state <= BUSY;
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign sel       = r_sel;
  assign out_data  = r_data;
  assign out_valid = (r_state == BUSY);
  assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_mux5_arbiter.sv
module tb_mux5_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req;
  logic [15:0] d_arr [5];
  logic [4:0]  gnt;
  logic [2:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  xfer_cnt;

  always #5 clk = ~clk;

  mux5_arbiter #(
    .DATA_W (16),
    .N_REQ  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d_arr[0]),
    .d1        (d_arr[1]),
    .d2        (d_arr[2]),
    .d3        (d_arr[3]),
    .d4        (d_arr[4]),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // reference model state
  int          m_ptr  = 0;
  bit          m_busy = 0;
  logic [7:0]  m_cnt  = '0;
  logic [2:0]  m_sel  = '0;
  logic [15:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: check gnt mid-cycle against the model, advance the model,
  // then compare the registered outputs just after the edge.
  task automatic cycle(output int win);
    logic [4:0] eg;
    bit         cap;
    exp_t       e;
    @(negedge clk);
    win = -1;
    eg  = '0;
    cap = !m_busy || out_ready;
    if (rst_n && cap && req != 5'd0) begin
      for (int k = 0; k < 5; k++) begin
        int idx;
        idx = (m_ptr + k) % 5;
        if (win < 0 && req[idx]) win = idx;
      end
      eg = 5'd1 << win;
    end
    check("gnt", {27'd0, gnt}, {27'd0, eg});
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_cnt = '0; m_sel = '0; m_data = '0;
      sb.delete();
    end else if (win >= 0) begin
      m_busy = 1;
      m_ptr  = (win + 1) % 5;
      m_cnt  = m_cnt + 8'd1;
      m_sel  = 3'(win);
      m_data = d_arr[win];
      sb.push_back('{m_sel, m_data, m_cnt});
    end else if (cap) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
    if (win >= 0) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("xfer sel=%0d data=%0d cnt=%0d", e.sel, e.data, e.cnt);
        check("valid", {31'd0, out_valid}, 32'd1);
        check("sel",   {29'd0, sel},       {29'd0, e.sel});
        check("data",  {16'd0, out_data},  {16'd0, e.data});
        check("cnt",   {24'd0, xfer_cnt},  {24'd0, e.cnt});
      end
    end else begin
      check("hold_valid", {31'd0, out_valid}, {31'd0, m_busy});
      check("hold_sel",   {29'd0, sel},       {29'd0, m_sel});
      check("hold_data",  {16'd0, out_data},  {16'd0, m_data});
      check("hold_cnt",   {24'd0, xfer_cnt},  {24'd0, m_cnt});
    end
  endtask

  task automatic do_reset();
    int w;
    rst_n = 1'b0;
    cycle(w);
    rst_n = 1'b1;
  endtask

  int          w;
  logic [15:0] rr_d [5];

  initial begin
    rst_n     = 1'b0;
    req       = 5'b11111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) d_arr[i] = 16'(i + 7);

    // Reset held two cycles with all requests active
    cycle(w);
    cycle(w);
    check("rst_gnt",   {27'd0, gnt},       32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sel",   {29'd0, sel},       32'd0);
    check("rst_data",  {16'd0, out_data},  32'd0);
    check("rst_cnt",   {24'd0, xfer_cnt},  32'd0);

    // Single request
    rst_n = 1'b1;
    d_arr[2] = 16'd1024;
    req = 5'b00100;
    #1;
    check("single_gnt", {27'd0, gnt}, 32'b00100);
    cycle(w);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data",  {16'd0, out_data},  32'd1024);
    check("single_sel",   {29'd0, sel},       32'd2);
    req = 5'b00000;
    cycle(w);

    // Round-robin with all requests held
    do_reset();
    rr_d[0] = 16'd400; rr_d[1] = 16'd974; rr_d[2] = 16'd1024;
    rr_d[3] = 16'd2059; rr_d[4] = 16'd4097;
    for (int i = 0; i < 5; i++) d_arr[i] = rr_d[i];
    req = 5'b11111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(w);
      check("rr_sel",  {29'd0, sel},      32'(k % 5));
      check("rr_data", {16'd0, out_data}, {16'd0, rr_d[k % 5]});
    end

    // Backpressure while holding 974
    cycle(w);
    check("bp_data0", {16'd0, out_data}, 32'd974);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_gnt", {27'd0, gnt}, 32'd0);
      cycle(w);
      check("bp_data", {16'd0, out_data}, 32'd974);
      check("bp_sel",  {29'd0, sel},      32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_gnt", {27'd0, gnt}, 32'b00100);
    cycle(w);
    check("bp_release_sel", {29'd0, sel}, 32'd2);

    // Wrap and skip from ptr=4
    do_reset();
    req = 5'b01000;
    cycle(w);
    req = 5'b01001;
    #1;
    check("ws_gnt0", {27'd0, gnt}, 32'b00001);
    cycle(w);
    check("ws_sel0", {29'd0, sel}, 32'd0);
    cycle(w);
    check("ws_sel3", {29'd0, sel}, 32'd3);

    // xfer_cnt wraps 255 -> 0 over 256 grants
    do_reset();
    req = 5'b11111;
    out_ready = 1'b1;
    for (int k = 0; k < 255; k++) begin
      for (int i = 0; i < 5; i++) d_arr[i] = 16'($urandom);
      cycle(w);
    end
    check("cnt_255", {24'd0, xfer_cnt}, 32'd255);
    cycle(w);
    check("cnt_wrap", {24'd0, xfer_cnt}, 32'd0);

    // Random traffic with random backpressure
    for (int k = 0; k < 200; k++) begin
      req       = 5'($urandom);
      out_ready = 1'($urandom);
      for (int i = 0; i < 5; i++) d_arr[i] = 16'($urandom);
      cycle(w);
    end

    // Mid-transfer reset
    req = 5'b00100;
    out_ready = 1'b1;
    cycle(w);
    out_ready = 1'b0;
    req = 5'b11111;
    rst_n = 1'b0;
    cycle(w);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("mid_rst_gnt", {27'd0, gnt}, 32'b00001);
    cycle(w);
    check("mid_rst_sel", {29'd0, sel}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
